// File: rtl/pipe_stall_ctrl.sv
// Front-end stall controller: owns the IF/ID register and turns hazard stalls, taken branches
// and HLT decode into PC write enable, IF/ID hold/flush and ID/EX bubble; keeps stall statistics.
module pipe_stall_ctrl #(
    parameter int unsigned          INSTR_W   = 16,
    parameter int unsigned          PC_W      = 16,
    parameter int unsigned          CNT_W     = 16,
    parameter int unsigned          MAX_STALL = 2,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = '0,
    parameter logic [3:0]           HLT_OP    = 4'hF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               NoOp,
    input  logic               BranchTaken,
    input  logic [INSTR_W-1:0] FetchInstr,
    input  logic [PC_W-1:0]    FetchPC2,
    output logic               PCWrite,
    output logic [INSTR_W-1:0] IFIDinstr,
    output logic [PC_W-1:0]    IFIDpc2,
    output logic               IFIDvalid,
    output logic               IDEXBubble,
    output logic               Halted,
    output logic [CNT_W-1:0]   StallCount,
    output logic               StallErr
);

    // Run-length counter only needs to reach MAX_STALL+1 before it saturates.
    localparam int unsigned       RunW     = $clog2(MAX_STALL + 2);
    localparam logic [RunW-1:0]   RunMax   = RunW'(MAX_STALL + 1);
    localparam logic [RunW-1:0]   RunLimit = RunW'(MAX_STALL);
    localparam logic [CNT_W-1:0]  CntOne   = CNT_W'(1);
    localparam logic [RunW-1:0]   RunOne   = RunW'(1);

    typedef enum logic [0:0] {StRun, StHalted} stateT;

    stateT              stateQ, stateD;
    logic [INSTR_W-1:0] ifidInstrQ, ifidInstrD;
    logic [PC_W-1:0]    ifidPc2Q, ifidPc2D;
    logic               ifidValidQ, ifidValidD;
    logic [CNT_W-1:0]   stallCountQ, stallCountD;
    logic [RunW-1:0]    runLenQ, runLenD;
    logic               stallErrQ, stallErrD;
    logic               isHlt;

    // An invalid slot never decodes as HLT, even if the NOP encoding shares the opcode.
    assign isHlt = ifidValidQ && (ifidInstrQ[INSTR_W-1 -: 4] == HLT_OP);

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ      <= StRun;
            ifidInstrQ  <= NOP_INSTR;
            ifidPc2Q    <= '0;
            ifidValidQ  <= 1'b0;
            stallCountQ <= '0;
            runLenQ     <= '0;
            stallErrQ   <= 1'b0;
        end else begin
            stateQ      <= stateD;
            ifidInstrQ  <= ifidInstrD;
            ifidPc2Q    <= ifidPc2D;
            ifidValidQ  <= ifidValidD;
            stallCountQ <= stallCountD;
            runLenQ     <= runLenD;
            stallErrQ   <= stallErrD;
        end
    end

    always_comb begin
        stateD      = stateQ;
        ifidInstrD  = ifidInstrQ;
        ifidPc2D    = ifidPc2Q;
        ifidValidD  = ifidValidQ;
        stallCountD = stallCountQ;
        runLenD     = runLenQ;
        stallErrD   = stallErrQ;
        PCWrite     = 1'b0;
        IDEXBubble  = 1'b0;

        case (stateQ)
            StRun: begin
                if (NoOp) begin
                    IDEXBubble = 1'b1;
                    if (stallCountQ != '1) begin
                        stallCountD = stallCountQ + CntOne;
                    end
                    if (runLenQ != RunMax) begin
                        runLenD = runLenQ + RunOne;
                    end
                    // This stall makes the run one longer than the legal maximum.
                    if (runLenQ >= RunLimit) begin
                        stallErrD = 1'b1;
                    end
                end else begin
                    runLenD = '0;
                    if (isHlt) begin
                        ifidInstrD = NOP_INSTR;
                        ifidValidD = 1'b0;
                        stateD     = StHalted;
                    end else if (BranchTaken) begin
                        PCWrite    = 1'b1;
                        ifidInstrD = NOP_INSTR;
                        ifidValidD = 1'b0;
                    end else begin
                        PCWrite    = 1'b1;
                        ifidInstrD = FetchInstr;
                        ifidPc2D   = FetchPC2;
                        ifidValidD = 1'b1;
                    end
                end
            end
            StHalted: begin
                IDEXBubble = 1'b1;
            end
            default: begin
                stateD = StRun;
            end
        endcase
    end

    assign IFIDinstr  = ifidInstrQ;
    assign IFIDpc2    = ifidPc2Q;
    assign IFIDvalid  = ifidValidQ;
    assign Halted     = (stateQ == StHalted);
    assign StallCount = stallCountQ;
    assign StallErr   = stallErrQ;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed vector table, multi-cycle corner sequences, then random
// stimulus against a behavioural model. A narrow-counter instance checks saturation.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst, noOp, branchTaken;
    logic [15:0] fetchInstr, fetchPc2;
    logic        pcWrite, ifidValid, idexBubble, halted, stallErr;
    logic [15:0] ifidInstr, ifidPc2, stallCount;
    logic        sPcWrite, sIfidValid, sIdexBubble, sHalted, sStallErr;
    logic [15:0] sIfidInstr, sIfidPc2;
    logic [3:0]  sStallCount;

    int nCmp = 0;
    int nFail = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl uDut (
        .clk(clk), .rst(rst), .NoOp(noOp), .BranchTaken(branchTaken),
        .FetchInstr(fetchInstr), .FetchPC2(fetchPc2), .PCWrite(pcWrite),
        .IFIDinstr(ifidInstr), .IFIDpc2(ifidPc2), .IFIDvalid(ifidValid),
        .IDEXBubble(idexBubble), .Halted(halted), .StallCount(stallCount),
        .StallErr(stallErr)
    );

    pipe_stall_ctrl #(.CNT_W(4)) uSmall (
        .clk(clk), .rst(rst), .NoOp(noOp), .BranchTaken(branchTaken),
        .FetchInstr(fetchInstr), .FetchPC2(fetchPc2), .PCWrite(sPcWrite),
        .IFIDinstr(sIfidInstr), .IFIDpc2(sIfidPc2), .IFIDvalid(sIfidValid),
        .IDEXBubble(sIdexBubble), .Halted(sHalted), .StallCount(sStallCount),
        .StallErr(sStallErr)
    );

    typedef struct {
        logic        rst, noOp, br;
        logic [15:0] instr, pc2;
        logic        chkComb, ePcw, eBub;
        logic [15:0] eInstr, ePc2;
        logic        eValid, eHalted;
        logic [15:0] eCnt;
        logic        eErr;
    } vecT;

    vecT vecs[13];

    function automatic vecT mk(input logic r, input logic n, input logic b,
                               input logic [15:0] i, input logic [15:0] p, input logic cc,
                               input logic pw, input logic bu, input logic [15:0] ei,
                               input logic [15:0] ep, input logic ev, input logic eh,
                               input logic [15:0] ec, input logic ee);
        vecT v;
        v.rst = r; v.noOp = n; v.br = b; v.instr = i; v.pc2 = p;
        v.chkComb = cc; v.ePcw = pw; v.eBub = bu; v.eInstr = ei; v.ePc2 = ep;
        v.eValid = ev; v.eHalted = eh; v.eCnt = ec; v.eErr = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic n, input logic b,
                         input logic [15:0] i, input logic [15:0] p);
        @(negedge clk);
        rst = r; noOp = n; branchTaken = b; fetchInstr = i; fetchPc2 = p;
    endtask

    // Behavioural reference: IF/ID contents, halt flag, unbounded stall totals.
    logic [15:0] mInstr, mPc2;
    bit          mValid, mHalted, mErr;
    int          mTotal, mRun;

    task automatic modelEdge(input logic r, input logic n, input logic b,
                             input logic [15:0] i, input logic [15:0] p);
        if (r) begin
            mInstr = 16'h0000; mPc2 = 16'h0000; mValid = 0; mHalted = 0;
            mErr = 0; mTotal = 0; mRun = 0;
        end else if (!mHalted) begin
            if (n) begin
                mTotal++;
                mRun++;
                if (mRun > 2) mErr = 1;
            end else begin
                mRun = 0;
                if (mValid && mInstr[15:12] == 4'hF) begin
                    mInstr = 16'h0000; mValid = 0; mHalted = 1;
                end else if (b) begin
                    mInstr = 16'h0000; mValid = 0;
                end else begin
                    mInstr = i; mPc2 = p; mValid = 1;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; noOp = 1'b0; branchTaken = 1'b0; fetchInstr = '0; fetchPc2 = '0;

        //          rst n  b  instr     pc2      cc pw bu eInstr    ePc2     ev eh eCnt ee
        vecs[0]  = mk(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 16'h1234, 16'h0002, 1, 1, 0, 16'h1234, 16'h0002, 1, 0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 16'h5678, 16'h0004, 1, 0, 1, 16'h1234, 16'h0002, 1, 0, 1, 0);
        vecs[3]  = mk(0, 1, 1, 16'h5678, 16'h0004, 1, 0, 1, 16'h1234, 16'h0002, 1, 0, 2, 0);
        vecs[4]  = mk(0, 0, 1, 16'h5678, 16'h0004, 1, 1, 0, 16'h0000, 16'h0002, 0, 0, 2, 0);
        vecs[5]  = mk(0, 0, 0, 16'hF000, 16'h0006, 1, 1, 0, 16'hF000, 16'h0006, 1, 0, 2, 0);
        vecs[6]  = mk(0, 0, 0, 16'h1111, 16'h0008, 1, 0, 0, 16'h0000, 16'h0006, 0, 1, 2, 0);
        vecs[7]  = mk(0, 1, 1, 16'h2222, 16'h000A, 1, 0, 1, 16'h0000, 16'h0006, 0, 1, 2, 0);
        vecs[8]  = mk(1, 1, 0, 16'h3333, 16'h000C, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        vecs[9]  = mk(0, 1, 0, 16'h4444, 16'h000E, 1, 0, 1, 16'h0000, 16'h0000, 0, 0, 1, 0);
        vecs[10] = mk(0, 1, 0, 16'h4444, 16'h000E, 1, 0, 1, 16'h0000, 16'h0000, 0, 0, 2, 0);
        vecs[11] = mk(0, 1, 0, 16'h4444, 16'h000E, 1, 0, 1, 16'h0000, 16'h0000, 0, 0, 3, 1);
        vecs[12] = mk(0, 0, 0, 16'hABCD, 16'h000A, 1, 1, 0, 16'hABCD, 16'h000A, 1, 0, 3, 1);

        for (int k = 0; k < 13; k++) begin
            drive(vecs[k].rst, vecs[k].noOp, vecs[k].br, vecs[k].instr, vecs[k].pc2);
            #1;
            if (vecs[k].chkComb) begin
                check($sformatf("vec%0d PCWrite", k), 32'(pcWrite), 32'(vecs[k].ePcw));
                check($sformatf("vec%0d IDEXBubble", k), 32'(idexBubble), 32'(vecs[k].eBub));
            end
            @(posedge clk); #1;
            check($sformatf("vec%0d IFIDinstr", k), 32'(ifidInstr), 32'(vecs[k].eInstr));
            check($sformatf("vec%0d IFIDpc2", k), 32'(ifidPc2), 32'(vecs[k].ePc2));
            check($sformatf("vec%0d IFIDvalid", k), 32'(ifidValid), 32'(vecs[k].eValid));
            check($sformatf("vec%0d Halted", k), 32'(halted), 32'(vecs[k].eHalted));
            check($sformatf("vec%0d StallCount", k), 32'(stallCount), 32'(vecs[k].eCnt));
            check($sformatf("vec%0d StallErr", k), 32'(stallErr), 32'(vecs[k].eErr));
        end

        // Halt and stay halted for 10 cycles regardless of NoOp/BranchTaken; reset exits.
        drive(0, 0, 0, 16'hF000, 16'h000C);
        drive(0, 0, 0, 16'h1234, 16'h000E);
        @(posedge clk); #1;
        check("halt entry Halted", 32'(halted), 32'd1);
        for (int k = 0; k < 10; k++) begin
            drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 16'h0);
            #1;
            check("halted PCWrite", 32'(pcWrite), 32'd0);
            check("halted IDEXBubble", 32'(idexBubble), 32'd1);
            @(posedge clk); #1;
            check("halted Halted", 32'(halted), 32'd1);
            check("halted IFIDvalid", 32'(ifidValid), 32'd0);
            check("halted IFIDinstr", 32'(ifidInstr), 32'h0);
        end
        drive(1, 0, 0, 16'h0, 16'h0);
        @(posedge clk); #1;
        check("halt reset Halted", 32'(halted), 32'd0);
        check("halt reset StallErr", 32'(stallErr), 32'd0);

        // Long stall: 4-bit counter saturates at F, 16-bit one keeps counting.
        for (int k = 0; k < 20; k++) drive(0, 1, 0, 16'h0, 16'h0);
        @(posedge clk); #1;
        check("sat small StallCount", 32'(sStallCount), 32'hF);
        check("sat big StallCount", 32'(stallCount), 32'd20);
        check("sat StallErr", 32'(sStallErr), 32'd1);

        // Random stimulus against the model.
        for (int k = 0; k < 3000; k++) begin
            logic        r, n, b;
            logic [15:0] i, p;
            r = (k == 0) || ($urandom_range(0, 99) < 2);
            n = ($urandom_range(0, 9) < 3);
            b = ($urandom_range(0, 9) < 3);
            i = 16'($urandom);
            if (i[15:12] == 4'hF && $urandom_range(0, 3) != 0) i[15] = 1'b0;
            p = 16'($urandom);
            drive(r, n, b, i, p);
            #1;
            if (!r) begin
                check("rand PCWrite", 32'(pcWrite),
                      32'(!mHalted && !n && !(mValid && mInstr[15:12] == 4'hF)));
                check("rand IDEXBubble", 32'(idexBubble), 32'(mHalted || n));
            end
            modelEdge(r, n, b, i, p);
            @(posedge clk); #1;
            check("rand IFIDinstr", 32'(ifidInstr), 32'(mInstr));
            check("rand IFIDpc2", 32'(ifidPc2), 32'(mPc2));
            check("rand IFIDvalid", 32'(ifidValid), 32'(mValid));
            check("rand Halted", 32'(halted), 32'(mHalted));
            check("rand StallCount", 32'(stallCount), 32'((mTotal > 65535) ? 65535 : mTotal));
            check("rand small StallCount", 32'(sStallCount), 32'((mTotal > 15) ? 15 : mTotal));
            check("rand StallErr", 32'(stallErr), 32'(mErr));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
